// File: rtl/bus_copy_engine_if.sv
// Bus copy engine control and bus signal bundle.
// The engine takes the master side; the environment takes the slave side.
interface bus_copy_engine_if;
  logic       start;
  logic [7:0] src;
  logic [7:0] dst;
  logic [7:0] len;
  logic       abort;
  logic       write;
  logic       read;
  logic [7:0] address;
  logic [7:0] dout;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] remaining;

  modport master (
    input  start, src, dst, len, abort, din,
    output write, read, address, dout,
    output busy, done, aborted, remaining
  );

  modport slave (
    output start, src, dst, len, abort, din,
    input  write, read, address, dout,
    input  busy, done, aborted, remaining
  );
endinterface

// File: rtl/bus_copy_engine.sv
// Byte copy engine: read source, wait one cycle, write destination.
// All bus and status outputs are registered from the next state.
module bus_copy_engine (
  input  logic clk,
  input  logic rst,
  bus_copy_engine_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WAIT,
    WR
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] dst_q, dst_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] dout_q, dout_d;
  logic       read_q, read_d;
  logic       write_q, write_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       abrt_q, abrt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= 8'h00;
      dst_q   <= 8'h00;
      rem_q   <= 8'h00;
      addr_q  <= 8'h00;
      dout_q  <= 8'h00;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      read_q  <= read_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    read_d  = 1'b0;
    write_d = 1'b0;
    done_d  = 1'b0;
    abrt_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // done_q high means the previous copy just ended; hold off one cycle
        if (bus.start && !done_q) begin
          if (bus.len != 8'h00) begin
            src_d   = bus.src;
            dst_d   = bus.dst;
            rem_d   = bus.len;
            addr_d  = bus.src;
            read_d  = 1'b1;
            state_d = RD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD: begin
        if (bus.abort) begin
          abrt_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.abort) begin
          abrt_d  = 1'b1;
          state_d = IDLE;
        end else begin
          dout_d  = bus.din;
          addr_d  = dst_q;
          write_d = 1'b1;
          state_d = WR;
        end
      end
      WR: begin
        rem_d = rem_q - 8'h01;
        src_d = src_q + 8'h01;
        dst_d = dst_q + 8'h01;
        if (bus.abort) begin
          abrt_d  = 1'b1;
          state_d = IDLE;
        end else if (rem_d != 8'h00) begin
          addr_d  = src_d;
          read_d  = 1'b1;
          state_d = RD;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.read      = read_q;
  assign bus.write     = write_q;
  assign bus.address   = addr_q;
  assign bus.dout      = dout_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = abrt_q;
  assign bus.remaining = rem_q;

endmodule

// File: tb/tb_bus_copy_engine.sv
// Scoreboard bench for bus_copy_engine with a read-only byte responder.
// Expected bus events come from a per-copy model of reads, writes and endings.
module tb_bus_copy_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bus_copy_engine_if bus();

  bus_copy_engine dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // kind: 0 read, 1 write, 2 done, 3 aborted; -1 fields are not checked
  typedef struct {
    int kind;
    int a;
    int d;
    int c;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] mem[256];
  int cyc = 0;
  int nchk = 0;
  int nbad = 0;
  int bs = 1;
  int be = 0;
  int rem_model = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    bus.din <= bus.read ? mem[bus.address] : 8'($urandom);

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", nm, got, exp, cyc);
    end
  endtask

  task automatic pop(input int kind, input int a, input int d);
    ev_t e;
    if (evq.size() == 0) begin
      nchk++;
      nbad++;
      $display("FAIL unexpected_event got kind=%0d exp none cyc=%0d",
               kind, cyc);
    end else begin
      e = evq.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cycle", cyc, e.c);
      if (e.a >= 0) chk("ev_addr", a, e.a);
      if (e.d >= 0) chk("ev_data", d, e.d);
    end
  endtask

  always @(negedge clk) begin
    chk("strobe_excl", {31'b0, bus.read & bus.write}, 0);
    chk("busy", bus.busy, (cyc >= bs && cyc < be));
    if (bus.read === 1'b1) pop(0, int'(bus.address), -1);
    if (bus.write === 1'b1) pop(1, int'(bus.address), int'(bus.dout));
    if (bus.done === 1'b1) pop(2, -1, -1);
    if (bus.aborted === 1'b1) pop(3, -1, -1);
  end

  // j: abort in cycle k+j (0 none); n: extra start pulse in cycle k+n
  task automatic run(input int s, input int d, input int l,
                     input int j, input int n);
    int k, t_end, wr, rd;
    bus.src   = 8'(s);
    bus.dst   = 8'(d);
    bus.len   = 8'(l);
    bus.start = 1'b1;
    bus.abort = 1'b0;
    @(posedge clk);
    #1;
    k = cyc;
    if (j > 0) begin
      wr    = (j - 1) / 3 + (((j - 1) % 3 == 2) ? 1 : 0);
      rd    = (j - 1) / 3 + 1;
      t_end = j + 1;
    end else begin
      wr    = l;
      rd    = l;
      t_end = 3 * l + 1;
    end
    for (int i = 0; i < rd; i++) begin
      evq.push_back('{0, (s + i) & 255, -1, k + 3 * i});
      if (i < wr)
        evq.push_back('{1, (d + i) & 255, int'(mem[(s + i) & 255]),
                        k + 3 * i + 2});
    end
    evq.push_back('{(j > 0) ? 3 : 2, -1, -1, k + t_end - 1});
    bs = k;
    be = k + t_end - 1;
    if (l != 0) rem_model = l - wr;
    for (int t = 1; t <= t_end; t++) begin
      bus.abort = (t == j);
      bus.start = (t == n);
      if (t == n) begin
        bus.src = 8'($urandom);
        bus.dst = 8'($urandom);
        bus.len = 8'($urandom_range(1, 255));
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("drained", evq.size(), 0);
    evq.delete();
    chk("remaining", bus.remaining, rem_model);
    chk("busy_end", bus.busy, 0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_read"}, bus.read, 0);
    chk({nm, "_write"}, bus.write, 0);
    chk({nm, "_addr"}, bus.address, 0);
    chk({nm, "_dout"}, bus.dout, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_aborted"}, bus.aborted, 0);
    chk({nm, "_rem"}, bus.remaining, 0);
  endtask

  initial begin
    int l, j, n, t_end;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.src   = 8'h00;
    bus.dst   = 8'h00;
    bus.len   = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hA1;
    mem[8'h11] = 8'hB2;
    mem[8'h12] = 8'hC3;

    #1 rst = 1'b0;
    #3 chk_reset_vals("por");
    @(posedge clk);
    #1 rst = 1'b1;

    run(8'h10, 8'h80, 3, 0, 0);
    run(8'hFE, 8'hFF, 3, 0, 0);
    run(8'h20, 8'h30, 0, 0, 0);
    run(8'h40, 8'h60, 4, 5, 0);
    run(8'h40, 8'h60, 4, 6, 0);
    run(8'h10, 8'h80, 3, 0, 4);
    run(8'h10, 8'h80, 3, 0, 10);
    run(8'h33, 8'h44, 2, 6, 0);

    bus.src   = 8'h40;
    bus.dst   = 8'h50;
    bus.len   = 8'h05;
    bus.start = 1'b1;
    bs = 0;
    be = 0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("rd_before_rst", bus.read, 1);
    #1 rst = 1'b0;
    #1 chk_reset_vals("mid_rd");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rem_model = 0;
    run(8'h10, 8'h80, 3, 0, 0);

    for (int r = 0; r < 40; r++) begin
      l = $urandom_range(0, 6);
      j = 0;
      if (l > 0 && $urandom_range(0, 2) == 0) j = $urandom_range(1, 3 * l);
      t_end = (j > 0) ? j + 1 : 3 * l + 1;
      n = ($urandom_range(0, 1) == 1) ? $urandom_range(1, t_end) : 0;
      if (j > 0 && n == t_end) n = 0;
      run($urandom_range(0, 255), $urandom_range(0, 255), l, j, n);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule

// File: doc/bus_copy_engine.md
BUS_COPY_ENGINE -- requirements
Module: bus_copy_engine

Interface
REQ-001 Parameters: none; bus address and data widths are fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset); release is seen at the next clk rising edge.
REQ-004 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-005 src  input  8  first source address; latched when start is accepted.
REQ-006 dst  input  8  first destination address; latched when start is accepted.
REQ-007 len  input  8  byte count, latched when start is accepted; 0 means no transfer.
REQ-008 abort  input  1  level request to stop the copy early.
REQ-009 write  output  1  bus write strobe, registered.
REQ-010 read  output  1  bus read strobe, registered.
REQ-011 address  output  8  bus address, registered.
REQ-012 dout  output  8  bus write data, registered.
REQ-013 din  input  8  bus read data from the responder.
REQ-014 busy  output  1  high while a copy is in progress.
REQ-015 done  output  1  one-cycle pulse when a copy completes normally.
REQ-016 aborted  output  1  one-cycle pulse when a copy ends because of abort.
REQ-017 remaining  output  8  bytes not yet written.

Function
REQ-018 The block SHALL act as the bus initiator.
REQ-019 Bus protocol:
- the block drives at most one strobe per cycle; read and write are never high together;
- each strobe is high for exactly one cycle, with address valid in that same cycle;
- the responder registers din at the rising edge that ends the read cycle;
- the block captures din at the rising edge that ends the following cycle (1-cycle read latency).
REQ-020 The FSM SHALL have four states: IDLE, RD, WAIT and WR.
REQ-021 IDLE: if start=1 and len!=0, latch src, dst and len, then go to RD.
REQ-022 IDLE: if start=1 and len=0, pulse done in the next cycle, issue no bus strobe and keep busy at 0.
REQ-023 RD: read=1, address=current source address; go to WAIT.
REQ-024 WAIT: read=0; capture din into the data register; go to WR.
REQ-025 WR: write=1, address=current destination address, dout=captured data. Also:
- decrement remaining;
- increment both source and destination addresses, modulo 256 (0xFF wraps to 0x00);
- go to RD if the new remaining is nonzero, otherwise to IDLE.
REQ-026 Throughput SHALL be 3 cycles per byte, back-to-back with no idle cycles between bytes.
REQ-027 First-strobe latency: start accepted at edge k gives read=1 in cycle k+1.
REQ-028 busy SHALL be high from the first RD cycle through the last WR cycle inclusive.
REQ-029 done SHALL pulse in the cycle after the last WR, the same cycle in which busy falls.
REQ-030 Outside RD, WR and the data-holding period, read=0 and write=0; address and dout hold their last values.
REQ-031 start SHALL be ignored while busy=1, including in the cycle done is high; start is accepted again the cycle after done.
REQ-032 abort=1 sampled in RD or WAIT:
- go to IDLE with no write for that byte;
- aborted pulses in the next cycle;
- remaining holds its value.
REQ-033 abort=1 sampled in WR:
- the write in that cycle completes and remaining decrements;
- go to IDLE with aborted pulsing next, not done.
REQ-034 If abort=1 in the final WR, abort SHALL take priority: aborted pulses and done does not.
REQ-035 abort SHALL be ignored in IDLE.
REQ-036 remaining SHALL equal len after acceptance and hold its value in IDLE.

Reset
REQ-037 While rst=0, all outputs SHALL be held at their reset values:
- write=0, read=0, address=0x00, dout=0x00;
- busy=0, done=0, aborted=0, remaining=0x00;
- FSM in IDLE.
REQ-038 Reset asserted mid-copy SHALL drop the strobes immediately (asynchronous), with no done or aborted pulse after release.
REQ-039 After reset release, the block SHALL accept start from the first rising edge.

Verification
REQ-040 Basic copy: src=0x10, dst=0x80, len=3, responder returns 0xA1, 0xB2, 0xC3:
- read/write cycles alternate: R 0x10, W 0x80=0xA1, R 0x11, W 0x81=0xB2, R 0x12, W 0x82=0xC3;
- done in cycle 10 after start; busy high for 9 cycles.
REQ-041 Wrap: src=0xFE, dst=0xFF, len=3 -> reads at 0xFE, 0xFF, 0x00 and writes at 0xFF, 0x00, 0x01.
REQ-042 Zero length: len=0 with start -> no strobes, busy stays 0, done pulses next cycle.
REQ-043 Abort:
- abort during the 2nd WAIT of len=4 -> exactly 1 write, aborted pulses, remaining=3, no done;
- abort during the 2nd WR -> 2 writes, remaining=2.
REQ-044 Busy start and reset:
- start pulsed mid-copy with different src -> ignored, original copy unchanged;
- rst=0 mid-RD -> read drops asynchronously, all outputs at reset values, idle after release.
